// File: rtl/dart_game_ctrl_if.sv
// Dart hit channel between the pattern generator (master) and the game controller (slave).
interface dart_game_ctrl_if;
    logic       dart_come_i;
    logic [7:0] dart_position_x_i;
    logic [7:0] dart_position_y_i;

    modport master (
        output dart_come_i,
        output dart_position_x_i,
        output dart_position_y_i
    );

    modport slave (
        input dart_come_i,
        input dart_position_x_i,
        input dart_position_y_i
    );
endinterface

// File: rtl/dart_game_ctrl.sv
// Two-player countdown dart game: scores each hit by ring distance from the board centre,
// alternates players every three darts, handles bust and exact-zero wins.
module dart_game_ctrl #(
    parameter int unsigned START_PT = 301,
    parameter int unsigned CX       = 128,
    parameter int unsigned CY       = 128,
    parameter int unsigned R_BULL   = 8,
    parameter int unsigned R1       = 32,
    parameter int unsigned R2       = 64,
    parameter int unsigned R3       = 100
) (
    input  logic                   clk,
    input  logic                   reset,
    dart_game_ctrl_if.slave        dart,
    output logic                   game_set_o,
    output logic                   player_1_done_o,
    output logic                   player_2_done_o,
    output logic                   player_1_win_o,
    output logic                   player_2_win_o,
    output logic [8:0]             player_1_pt_o,
    output logic [8:0]             player_2_pt_o
);

    localparam logic [16:0] BullSq = 17'(R_BULL * R_BULL);
    localparam logic [16:0] R1Sq   = 17'(R1 * R1);
    localparam logic [16:0] R2Sq   = 17'(R2 * R2);
    localparam logic [16:0] R3Sq   = 17'(R3 * R3);
    localparam logic [8:0]  StartPt = 9'(START_PT);

    typedef enum logic [1:0] {StWaitDart, StCalc, StApply, StGameOver} state_e;

    state_e      state_q, state_d;
    logic [7:0]  x_q, x_d, y_q, y_d;
    logic [16:0] d2_q, d2_d;
    logic        player_q, player_d;   // 0: player 1, 1: player 2
    logic [1:0]  dart_cnt_q, dart_cnt_d;
    logic [8:0]  p1_pt_q, p1_pt_d, p2_pt_q, p2_pt_d;
    logic [8:0]  turn_start_q, turn_start_d;
    logic        done1_q, done1_d, done2_q, done2_d;
    logic        win1_q, win1_d, win2_q, win2_d;
    logic        game_set_q, game_set_d;

    logic signed [8:0]  dx, dy;
    logic signed [17:0] dx2, dy2;
    logic [16:0]        d2_calc;
    logic [8:0]         score, cur_pt, new_pt;
    logic               turn_end;

    assign dx      = $signed({1'b0, x_q}) - $signed(9'(CX));
    assign dy      = $signed({1'b0, y_q}) - $signed(9'(CY));
    assign dx2     = dx * dx;
    assign dy2     = dy * dy;
    assign d2_calc = 17'(unsigned'(dx2)) + 17'(unsigned'(dy2));
    assign cur_pt  = player_q ? p2_pt_q : p1_pt_q;

    // Ring boundaries are inclusive: a hit exactly on a radius scores the inner ring.
    always_comb begin
        score = 9'd0;
        if      (d2_q <= BullSq) score = 9'd50;
        else if (d2_q <= R1Sq)   score = 9'd20;
        else if (d2_q <= R2Sq)   score = 9'd10;
        else if (d2_q <= R3Sq)   score = 9'd5;
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        d2_d         = d2_q;
        player_d     = player_q;
        dart_cnt_d   = dart_cnt_q;
        p1_pt_d      = p1_pt_q;
        p2_pt_d      = p2_pt_q;
        turn_start_d = turn_start_q;
        done1_d      = 1'b0;
        done2_d      = 1'b0;
        win1_d       = win1_q;
        win2_d       = win2_q;
        game_set_d   = game_set_q;
        new_pt       = cur_pt;
        turn_end     = 1'b0;

        unique case (state_q)
            StWaitDart: begin
                if (dart.dart_come_i) begin
                    x_d     = dart.dart_position_x_i;
                    y_d     = dart.dart_position_y_i;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                d2_d    = d2_calc;
                state_d = StApply;
            end
            StApply: begin
                state_d = StWaitDart;
                if (score > cur_pt) begin
                    new_pt   = turn_start_q;
                    turn_end = 1'b1;
                end else if (score == cur_pt) begin
                    new_pt     = 9'd0;
                    turn_end   = 1'b1;
                    game_set_d = 1'b1;
                    state_d    = StGameOver;
                    if (player_q) win2_d = 1'b1;
                    else          win1_d = 1'b1;
                end else begin
                    new_pt   = cur_pt - score;
                    turn_end = (dart_cnt_q == 2'd2);
                end

                if (player_q) p2_pt_d = new_pt;
                else          p1_pt_d = new_pt;

                if (turn_end) begin
                    // The incoming player's points are untouched this cycle, so snapshot the register.
                    player_d     = ~player_q;
                    dart_cnt_d   = 2'd0;
                    turn_start_d = player_q ? p1_pt_q : p2_pt_q;
                    if (player_q) done2_d = 1'b1;
                    else          done1_d = 1'b1;
                end else begin
                    dart_cnt_d = dart_cnt_q + 2'd1;
                end
            end
            StGameOver: state_d = StGameOver;
            default:    state_d = StWaitDart;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StWaitDart;
            x_q          <= 8'd0;
            y_q          <= 8'd0;
            d2_q         <= 17'd0;
            player_q     <= 1'b0;
            dart_cnt_q   <= 2'd0;
            p1_pt_q      <= StartPt;
            p2_pt_q      <= StartPt;
            turn_start_q <= StartPt;
            done1_q      <= 1'b0;
            done2_q      <= 1'b0;
            win1_q       <= 1'b0;
            win2_q       <= 1'b0;
            game_set_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            d2_q         <= d2_d;
            player_q     <= player_d;
            dart_cnt_q   <= dart_cnt_d;
            p1_pt_q      <= p1_pt_d;
            p2_pt_q      <= p2_pt_d;
            turn_start_q <= turn_start_d;
            done1_q      <= done1_d;
            done2_q      <= done2_d;
            win1_q       <= win1_d;
            win2_q       <= win2_d;
            game_set_q   <= game_set_d;
        end
    end

    assign game_set_o      = game_set_q;
    assign player_1_done_o = done1_q;
    assign player_2_done_o = done2_q;
    assign player_1_win_o  = win1_q;
    assign player_2_win_o  = win2_q;
    assign player_1_pt_o   = p1_pt_q;
    assign player_2_pt_o   = p2_pt_q;

endmodule
